// File: rtl/bitcoin_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bitcoin_pkg : shared types, widths and helpers for the hash engine
// Rev 1.0
// ----------------------------------------------------------------------------
package bitcoin_pkg;

  localparam int NONCE_W = 32;
  localparam int WORD_W  = 32;
  localparam int ADDR_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

  // Index of the lowest set bit; zero when nothing is set (caller checks |vec).
  function automatic logic [4:0] lowest_set_idx(input logic [31:0] vec);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter : round-robin arbiter, search starts one past the last grant
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 16,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx,
  output logic          o_valid
);

  logic [IW-1:0] r_ptr;
  logic [IW:0]   w_cand;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_valid     = 1'b0;
    w_cand      = '0;
    for (int i = 0; i < N; i++) begin
      w_cand = {1'b0, r_ptr} + (IW+1)'(i);
      if (w_cand >= (IW+1)'(N)) w_cand = w_cand - (IW+1)'(N);
      if (!o_valid && i_req[w_cand[IW-1:0]]) begin
        o_valid     = 1'b1;
        o_grant_idx = w_cand[IW-1:0];
      end
    end
    if (o_valid) o_grant[o_grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (o_valid) begin
      r_ptr <= (o_grant_idx == IW'(N-1)) ? '0 : o_grant_idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nonce_dispatch_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nonce_dispatch_ctrl : hands nonces to idle hash cores, writes results back
// Rev 1.0
// ----------------------------------------------------------------------------
module nonce_dispatch_ctrl
  import bitcoin_pkg::*;
#(
  parameter int NUM_CORES = 16,
  parameter int IDX_W     = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_start,
  input  logic [NONCE_W-1:0]            i_nonce_base,
  input  logic [IDX_W-1:0]              i_nonce_count,
  input  logic [ADDR_W-1:0]             i_output_addr,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [NUM_CORES-1:0]          o_core_start,
  output logic [NONCE_W*NUM_CORES-1:0]  o_core_nonce,
  input  logic [NUM_CORES-1:0]          i_core_done,
  input  logic [WORD_W*NUM_CORES-1:0]   i_core_hash,
  output logic [NUM_CORES-1:0]          o_core_ack,
  output logic                          o_mem_clk,
  output logic                          o_mem_we,
  output logic [ADDR_W-1:0]             o_mem_addr,
  output logic [WORD_W-1:0]             o_mem_write_data
);

  localparam int CIW = $clog2(NUM_CORES);

  ctrl_state_t          r_state;
  ctrl_state_t          w_next_state;

  logic [NONCE_W-1:0]   r_base;
  logic [IDX_W-1:0]     r_count;
  logic [ADDR_W-1:0]    r_out_addr;
  logic [IDX_W-1:0]     r_issued;

  logic [NUM_CORES-1:0] r_core_busy;
  logic [NUM_CORES-1:0] r_core_start;
  logic [NUM_CORES-1:0] r_core_ack;
  logic [NONCE_W-1:0]   r_core_nonce [NUM_CORES];
  logic [IDX_W-1:0]     r_offset     [NUM_CORES];

  logic                 r_mem_we;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [WORD_W-1:0]    r_mem_data;

  logic                 w_accept;
  logic                 w_issue;
  logic                 w_job_complete;
  logic [31:0]          w_idle_ext;
  logic [4:0]           w_disp_sel;
  logic [NUM_CORES-1:0] w_disp_onehot;
  logic [NUM_CORES-1:0] w_req;
  logic [NUM_CORES-1:0] w_grant;
  logic [CIW-1:0]       w_grant_idx;
  logic                 w_grant_valid;
  logic [WORD_W-1:0]    w_core_hash  [NUM_CORES];

  genvar gk;
  generate
    for (gk = 0; gk < NUM_CORES; gk++) begin : g_core_io
      assign w_core_hash[gk]                      = i_core_hash[gk*WORD_W +: WORD_W];
      assign o_core_nonce[gk*NONCE_W +: NONCE_W]  = r_core_nonce[gk];
    end
  endgenerate

  assign w_accept = i_start && ((r_state == IDLE) || (r_state == DONE));

  // Dispatch: lowest-index idle core takes the next nonce offset.
  always_comb begin
    w_idle_ext                = '0;
    w_idle_ext[NUM_CORES-1:0] = ~r_core_busy;
  end

  assign w_disp_sel = lowest_set_idx(w_idle_ext);
  assign w_issue    = (r_state == RUN) && (r_issued < r_count) && (|(~r_core_busy));

  always_comb begin
    w_disp_onehot = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_disp_onehot[k] = w_issue && (w_disp_sel == 5'(k));
    end
  end

  // A core in its ack cycle is masked so it cannot be granted twice.
  assign w_req = i_core_done & r_core_busy & ~r_core_ack;

  rr_arbiter #(
    .N  (NUM_CORES),
    .IW (CIW)
  ) u_rr_arbiter (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_req       (w_req),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_valid     (w_grant_valid)
  );

  // A grant this cycle is a write still in flight; done waits until it lands.
  assign w_job_complete = (r_issued == r_count) && !(|r_core_busy) && !w_grant_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept)       w_next_state = RUN;
      RUN:     if (w_job_complete) w_next_state = DONE;
      DONE:    if (w_accept)       w_next_state = RUN;
      default:                     w_next_state = IDLE;
    endcase
  end

  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      RUN:     o_busy = 1'b1;
      DONE:    o_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base       <= '0;
      r_count      <= '0;
      r_out_addr   <= '0;
      r_issued     <= '0;
      r_core_busy  <= '0;
      r_core_start <= '0;
      r_core_ack   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      for (int k = 0; k < NUM_CORES; k++) begin
        r_core_nonce[k] <= '0;
        r_offset[k]     <= '0;
      end
    end else begin
      r_core_start <= w_disp_onehot;
      r_core_ack   <= w_grant;
      r_core_busy  <= (r_core_busy | w_disp_onehot) & ~w_grant;
      r_mem_we     <= w_grant_valid;
      if (w_grant_valid) begin
        r_mem_addr <= r_out_addr + ADDR_W'(r_offset[w_grant_idx]);
        r_mem_data <= w_core_hash[w_grant_idx];
      end
      if (w_accept) begin
        r_base     <= i_nonce_base;
        r_count    <= i_nonce_count;
        r_out_addr <= i_output_addr;
        r_issued   <= '0;
      end else if (w_issue) begin
        r_issued   <= r_issued + 1'b1;
      end
      for (int k = 0; k < NUM_CORES; k++) begin
        if (w_disp_onehot[k]) begin
          r_core_nonce[k] <= r_base + NONCE_W'(r_issued);
          r_offset[k]     <= r_issued;
        end
      end
    end
  end

  assign o_core_start     = r_core_start;
  assign o_core_ack       = r_core_ack;
  assign o_mem_clk        = clk;
  assign o_mem_we         = r_mem_we;
  assign o_mem_addr       = r_mem_addr;
  assign o_mem_write_data = r_mem_data;

endmodule
`default_nettype wire

// File: tb/tb_nonce_dispatch_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_nonce_dispatch_ctrl : randomized bench with behavioural hash-core pool
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_nonce_dispatch_ctrl;

  localparam int NC = 16;

  logic            clk;
  logic            reset_n;
  logic            i_start;
  logic [31:0]     i_nonce_base;
  logic [15:0]     i_nonce_count;
  logic [15:0]     i_output_addr;
  logic            o_busy;
  logic            o_done;
  logic [NC-1:0]   o_core_start;
  logic [32*NC-1:0] o_core_nonce;
  logic [NC-1:0]   i_core_done;
  logic [32*NC-1:0] i_core_hash;
  logic [NC-1:0]   o_core_ack;
  logic            o_mem_clk;
  logic            o_mem_we;
  logic [15:0]     o_mem_addr;
  logic [31:0]     o_mem_write_data;

  int n_checks;
  int n_errors;
  int cyc;

  // Core-pool model state
  bit          c_busy  [NC];
  int          c_cnt   [NC];
  logic [31:0] c_nonce [NC];
  int          lat_lo;
  int          lat_hi;
  bit          hold;
  int          n_starts;
  int          bad_start;
  int          bad_ack;
  int          bad_stable;
  int          last_ack_core;

  logic [15:0] wr_addr  [$];
  logic [31:0] wr_data  [$];
  int          wr_cyc   [$];
  int          wr_core  [$];
  int          st_cyc   [$];
  int          st_core  [$];
  logic [31:0] st_nonce [$];

  int t_edge;

  nonce_dispatch_ctrl #(.NUM_CORES(NC), .IDX_W(16)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_start          (i_start),
    .i_nonce_base     (i_nonce_base),
    .i_nonce_count    (i_nonce_count),
    .i_output_addr    (i_output_addr),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_core_start     (o_core_start),
    .o_core_nonce     (o_core_nonce),
    .i_core_done      (i_core_done),
    .i_core_hash      (i_core_hash),
    .o_core_ack       (o_core_ack),
    .o_mem_clk        (o_mem_clk),
    .o_mem_we         (o_mem_we),
    .o_mem_addr       (o_mem_addr),
    .o_mem_write_data (o_mem_write_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] hash(input logic [31:0] n);
    return (n * 32'h9E37_79B1) ^ {n[15:0], n[31:16]} ^ 32'hA5A5_0F0F;
  endfunction

  // Behavioural hash cores: take a nonce on core_start, answer after a latency,
  // hold done until acked. Also records every start and every memory write.
  initial begin
    i_core_done   = '0;
    i_core_hash   = '0;
    last_ack_core = NC-1;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        for (int k = 0; k < NC; k++) begin
          c_busy[k] = 1'b0;
          c_cnt[k]  = 0;
        end
        i_core_done   = '0;
        last_ack_core = NC-1;
      end else begin
        if ((o_core_ack != '0) && ($countones(o_core_ack) != 1)) bad_ack++;
        if (o_mem_we !== (o_core_ack != '0)) bad_ack++;
        for (int k = 0; k < NC; k++) begin
          if (o_core_ack[k]) begin
            if (!c_busy[k] || !i_core_done[k]) bad_ack++;
            c_busy[k]      = 1'b0;
            i_core_done[k] = 1'b0;
            last_ack_core  = k;
            if (o_mem_we) wr_core.push_back(k);
          end
        end
        if (o_mem_we) begin
          wr_addr.push_back(o_mem_addr);
          wr_data.push_back(o_mem_write_data);
          wr_cyc.push_back(cyc);
        end
        for (int k = 0; k < NC; k++) begin
          if (o_core_start[k]) begin
            n_starts++;
            if (c_busy[k]) bad_start++;
            c_busy[k]  = 1'b1;
            c_nonce[k] = o_core_nonce[k*32 +: 32];
            c_cnt[k]   = $urandom_range(lat_hi, lat_lo);
            st_cyc.push_back(cyc);
            st_core.push_back(k);
            st_nonce.push_back(o_core_nonce[k*32 +: 32]);
          end else if (c_busy[k]) begin
            if (o_core_nonce[k*32 +: 32] !== c_nonce[k]) bad_stable++;
            if (!i_core_done[k]) begin
              if (c_cnt[k] > 0) c_cnt[k]--;
              if (c_cnt[k] == 0 && !hold) begin
                i_core_done[k]          = 1'b1;
                i_core_hash[k*32 +: 32] = hash(c_nonce[k]);
              end
            end
          end
        end
      end
    end
  end

  task automatic clear_job();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); wr_core.delete();
    st_cyc.delete();  st_core.delete(); st_nonce.delete();
    n_starts = 0; bad_start = 0; bad_ack = 0; bad_stable = 0;
  endtask

  task automatic start_job(input logic [31:0] base, input logic [15:0] cnt, input logic [15:0] addr);
    @(negedge clk);
    i_nonce_base  = base;
    i_nonce_count = cnt;
    i_output_addr = addr;
    i_start       = 1'b1;
    clear_job();
    @(negedge clk);
    i_start = 1'b0;
    t_edge  = cyc;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int done_cyc);
    ok       = 1'b0;
    done_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_done) begin
        ok       = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
  endtask

  // Reference: every offset 0..cnt-1 written once to addr+off with hash(base+off).
  function automatic int job_errors(input logic [31:0] base, input logic [15:0] cnt, input logic [15:0] addr);
    bit          seen [int];
    int          e;
    logic [15:0] off;
    e = 0;
    if (wr_addr.size() != int'(cnt)) e++;
    foreach (wr_addr[j]) begin
      off = wr_addr[j] - addr;
      if (off >= cnt) e++;
      else if (seen.exists(int'(off))) e++;
      else begin
        seen[int'(off)] = 1'b1;
        if (wr_data[j] !== hash(base + 32'(off))) e++;
      end
    end
    return e;
  endfunction

  function automatic int nonce_errors(input logic [31:0] base, input logic [15:0] cnt);
    bit          seen [int];
    int          e;
    logic [31:0] off;
    e = 0;
    if (st_nonce.size() != int'(cnt)) e++;
    foreach (st_nonce[j]) begin
      off = st_nonce[j] - base;
      if (off >= 32'(cnt)) e++;
      else if (seen.exists(int'(off))) e++;
      else seen[int'(off)] = 1'b1;
    end
    return e;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %0b want 0", o_busy); end
    n_checks++; if (o_done !== 1'b0) begin n_errors++; $display("FAIL rst_done: got %0b want 0", o_done); end
    n_checks++; if (o_core_start !== '0) begin n_errors++; $display("FAIL rst_core_start: got %h want 0", o_core_start); end
    n_checks++; if (o_core_ack !== '0) begin n_errors++; $display("FAIL rst_core_ack: got %h want 0", o_core_ack); end
    n_checks++; if (o_core_nonce !== '0) begin n_errors++; $display("FAIL rst_core_nonce: got nonzero want 0"); end
    n_checks++; if (o_mem_we !== 1'b0) begin n_errors++; $display("FAIL rst_mem_we: got %0b want 0", o_mem_we); end
    n_checks++; if (o_mem_addr !== 16'h0) begin n_errors++; $display("FAIL rst_mem_addr: got %h want 0", o_mem_addr); end
    n_checks++; if (o_mem_write_data !== 32'h0) begin n_errors++; $display("FAIL rst_mem_data: got %h want 0", o_mem_write_data); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin n_errors++; $display("FAIL idle_flags: got busy=%0b done=%0b want 0/0", o_busy, o_done); end
    #2;
    n_checks++; if (o_mem_clk !== clk) begin n_errors++; $display("FAIL mem_clk: got %0b want %0b", o_mem_clk, clk); end
  endtask

  task automatic test_fixed_latency();
    bit ok; int dc; int bad;
    lat_lo = 64; lat_hi = 64; hold = 1'b0;
    start_job(32'h0, 16'd16, 16'h0100);
    n_checks++; if (o_busy !== 1'b1 || o_done !== 1'b0) begin n_errors++; $display("FAIL fix_busy: got busy=%0b done=%0b want 1/0", o_busy, o_done); end
    wait_done(400, ok, dc);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL fix_timeout: done not seen, got 0 want 1"); end
    n_checks++; if (n_starts !== 16) begin n_errors++; $display("FAIL fix_starts: got %0d want 16", n_starts); end
    bad = 0;
    foreach (st_cyc[j]) if (st_core[j] != j || st_cyc[j] != t_edge + 1 + j || st_nonce[j] !== 32'(j)) bad++;
    n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL fix_start_seq: got %0d bad starts want 0", bad); end
    n_checks++; if (wr_addr.size() !== 16) begin n_errors++; $display("FAIL fix_nwrites: got %0d want 16", wr_addr.size()); end
    bad = 0;
    foreach (wr_addr[j]) if (wr_addr[j] !== 16'h0100 + 16'(j) || wr_data[j] !== hash(32'(j))) bad++;
    n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL fix_writes: got %0d bad writes want 0", bad); end
    if (wr_cyc.size() > 0) begin
      n_checks++; if (dc !== wr_cyc[wr_cyc.size()-1] + 1) begin n_errors++; $display("FAIL fix_done_time: got %0d want %0d", dc, wr_cyc[wr_cyc.size()-1] + 1); end
    end
    n_checks++; if (bad_start + bad_ack + bad_stable !== 0) begin n_errors++; $display("FAIL fix_protocol: got %0d/%0d/%0d want 0/0/0", bad_start, bad_ack, bad_stable); end
  endtask

  task automatic test_random_latency();
    bit ok; int dc; logic [31:0] base; logic [15:0] addr;
    lat_lo = 5; lat_hi = 80; hold = 1'b0;
    base = $urandom; addr = 16'($urandom);
    start_job(base, 16'd40, addr);
    repeat (20) @(negedge clk);
    // A start arriving mid-job must leave the running job untouched.
    i_nonce_base = ~base; i_nonce_count = 16'd3; i_output_addr = ~addr; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    n_checks++; if (o_busy !== 1'b1 || o_done !== 1'b0) begin n_errors++; $display("FAIL rnd_ignore_start: got busy=%0b done=%0b want 1/0", o_busy, o_done); end
    wait_done(3000, ok, dc);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL rnd_timeout: done not seen, got 0 want 1"); end
    n_checks++; if (job_errors(base, 16'd40, addr) !== 0) begin n_errors++; $display("FAIL rnd_writes: got %0d errors want 0", job_errors(base, 16'd40, addr)); end
    n_checks++; if (nonce_errors(base, 16'd40) !== 0) begin n_errors++; $display("FAIL rnd_nonces: got %0d errors want 0", nonce_errors(base, 16'd40)); end
    n_checks++; if (n_starts !== 40) begin n_errors++; $display("FAIL rnd_starts: got %0d want 40", n_starts); end
    n_checks++; if (bad_start + bad_ack + bad_stable !== 0) begin n_errors++; $display("FAIL rnd_protocol: got %0d/%0d/%0d want 0/0/0", bad_start, bad_ack, bad_stable); end
    if (wr_cyc.size() > 0) begin
      n_checks++; if (dc !== wr_cyc[wr_cyc.size()-1] + 1) begin n_errors++; $display("FAIL rnd_done_time: got %0d want %0d", dc, wr_cyc[wr_cyc.size()-1] + 1); end
    end
  endtask

  task automatic test_simultaneous();
    bit ok; int dc; int p; int bad; logic [31:0] base; logic [15:0] addr;
    lat_lo = 1; lat_hi = 1; hold = 1'b1;
    p = last_ack_core;
    base = $urandom; addr = 16'($urandom);
    start_job(base, 16'd16, addr);
    repeat (24) @(negedge clk);
    n_checks++; if (n_starts !== 16 || wr_addr.size() !== 0) begin n_errors++; $display("FAIL sim_prefill: got starts=%0d writes=%0d want 16/0", n_starts, wr_addr.size()); end
    hold = 1'b0;
    wait_done(200, ok, dc);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL sim_timeout: done not seen, got 0 want 1"); end
    n_checks++; if (wr_core.size() !== 16) begin n_errors++; $display("FAIL sim_nacks: got %0d want 16", wr_core.size()); end
    bad = 0;
    foreach (wr_core[j]) if (wr_core[j] != (p + 1 + j) % NC || wr_cyc[j] != wr_cyc[0] + j) bad++;
    n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL sim_rr_order: got %0d out-of-order/gapped writes want 0", bad); end
    n_checks++; if (job_errors(base, 16'd16, addr) !== 0) begin n_errors++; $display("FAIL sim_writes: got %0d errors want 0", job_errors(base, 16'd16, addr)); end
  endtask

  task automatic test_zero_count();
    start_job($urandom, 16'd0, 16'h1234);
    n_checks++; if (o_busy !== 1'b1 || o_done !== 1'b0) begin n_errors++; $display("FAIL zero_busy: got busy=%0b done=%0b want 1/0", o_busy, o_done); end
    @(negedge clk);
    n_checks++; if (o_busy !== 1'b0 || o_done !== 1'b1) begin n_errors++; $display("FAIL zero_done: got busy=%0b done=%0b want 0/1", o_busy, o_done); end
    repeat (5) @(negedge clk);
    n_checks++; if (n_starts !== 0 || wr_addr.size() !== 0) begin n_errors++; $display("FAIL zero_activity: got starts=%0d writes=%0d want 0/0", n_starts, wr_addr.size()); end
  endtask

  task automatic test_wrap();
    bit ok; int dc; int bad; logic [15:0] ea; logic [31:0] en;
    lat_lo = 10; lat_hi = 10; hold = 1'b0;
    start_job(32'hFFFF_FFFE, 16'd8, 16'hFFFC);
    wait_done(200, ok, dc);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL wrap_timeout: done not seen, got 0 want 1"); end
    n_checks++; if (wr_addr.size() !== 8 || st_nonce.size() !== 8) begin n_errors++; $display("FAIL wrap_counts: got writes=%0d starts=%0d want 8/8", wr_addr.size(), st_nonce.size()); end
    bad = 0;
    ea = 16'hFFFC; en = 32'hFFFF_FFFE;
    foreach (wr_addr[j]) if (wr_addr[j] !== ea + 16'(j)) bad++;
    foreach (st_nonce[j]) if (st_nonce[j] !== en + 32'(j)) bad++;
    n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL wrap_seq: got %0d bad addr/nonce want 0", bad); end
    if (wr_addr.size() > 4) begin
      n_checks++; if (wr_addr[4] !== 16'h0000) begin n_errors++; $display("FAIL wrap_addr4: got %h want 0000", wr_addr[4]); end
    end
    if (st_nonce.size() > 2) begin
      n_checks++; if (st_nonce[2] !== 32'h0) begin n_errors++; $display("FAIL wrap_nonce2: got %h want 00000000", st_nonce[2]); end
    end
    n_checks++; if (job_errors(32'hFFFF_FFFE, 16'd8, 16'hFFFC) !== 0) begin n_errors++; $display("FAIL wrap_writes: got %0d errors want 0", job_errors(32'hFFFF_FFFE, 16'd8, 16'hFFFC)); end
  endtask

  task automatic test_reset_mid_run();
    lat_lo = 5; lat_hi = 80; hold = 1'b0;
    start_job($urandom, 16'd40, 16'($urandom));
    repeat (29) @(negedge clk);
    n_checks++; if (o_busy !== 1'b1) begin n_errors++; $display("FAIL mid_busy_before: got %0b want 1", o_busy); end
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++; if (o_busy !== 1'b0 || o_done !== 1'b0 || o_core_start !== '0 || o_core_ack !== '0) begin
      n_errors++; $display("FAIL mid_rst_ctrl: got busy=%0b done=%0b start=%h ack=%h want all 0", o_busy, o_done, o_core_start, o_core_ack); end
    n_checks++; if (o_mem_we !== 1'b0 || o_mem_addr !== 16'h0 || o_mem_write_data !== 32'h0 || o_core_nonce !== '0) begin
      n_errors++; $display("FAIL mid_rst_mem: got we=%0b addr=%h data=%h want all 0", o_mem_we, o_mem_addr, o_mem_write_data); end
    reset_n = 1'b1;
    clear_job();
    repeat (40) @(negedge clk);
    n_checks++; if (n_starts !== 0 || wr_addr.size() !== 0) begin n_errors++; $display("FAIL mid_after: got starts=%0d writes=%0d want 0/0", n_starts, wr_addr.size()); end
    n_checks++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin n_errors++; $display("FAIL mid_idle: got busy=%0b done=%0b want 0/0", o_busy, o_done); end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    reset_n = 1'b0; i_start = 1'b0;
    i_nonce_base = '0; i_nonce_count = '0; i_output_addr = '0;
    lat_lo = 1; lat_hi = 1; hold = 1'b0;
    clear_job();
    test_reset();
    test_fixed_latency();
    test_random_latency();
    test_simultaneous();
    test_zero_count();
    test_wrap();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
